sdram_burst_bridge: RTL and testbench

Command/stream front end for `sdram_controller`, sitting directly upstream of it in the 100 MHz SDRAM clock domain. Accepts burst read/write commands plus a write-data stream from the MCU side, buffers write data in an internal FIFO, and drives the controller's `*_req`/`*_addr`/`*_burst`/`sdram_din` ports with a correct handshake. Returns read data as a registered stream, and reports completion or error per command.

---
 rtl/sdram_burst_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_sdram_burst_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_bridge.sv
// Command/stream front end for sdram_controller: show-ahead write FIFO, req/ack handshake, burst FSM.
// Define SDRAM_BRIDGE_STATS_EN to add wr_bursts/rd_bursts/err_count statistics outputs.
module sdram_burst_bridge #(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_done_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [23:0] cmd_addr_i,
    input  logic [9:0]  cmd_len_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    input  logic [15:0] wdata_i,
    output logic        rdata_valid_o,
    output logic [15:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
`ifdef SDRAM_BRIDGE_STATS_EN
    output logic [15:0] wr_bursts_o,
    output logic [15:0] rd_bursts_o,
    output logic [7:0]  err_count_o,
`endif
    output logic        sdram_wr_req_o,
    input  logic        sdram_wr_ack_i,
    output logic [23:0] sdram_wr_addr_o,
    output logic [9:0]  sdram_wr_burst_o,
    output logic [15:0] sdram_din_o,
    output logic        sdram_rd_req_o,
    input  logic        sdram_rd_ack_i,
    output logic [23:0] sdram_rd_addr_o,
    output logic [9:0]  sdram_rd_burst_o,
    input  logic [15:0] sdram_dout_i
);
    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned CntW  = FIFO_AW + 1;
    localparam int unsigned TmrW  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StWaitData, StWrReq, StWrBurst, StRdReq, StRdBurst
    } state_e;

    state_e          state_q, state_d;
    logic [23:0]     addr_q, addr_d;
    logic [9:0]      len_q, len_d;
    logic            dir_q, dir_d;
    logic [9:0]      beat_q, beat_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            rvalid_q;
    logic [15:0]     rdata_q;
    logic            ack;
    logic            rd_phase;

    logic [15:0]        mem_q [Depth];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0]    cnt_q;
    logic [CntW-1:0]    pop_n;
    logic               full;
    logic               push;

    assign ack      = dir_q ? sdram_wr_ack_i : sdram_rd_ack_i;
    assign rd_phase = (state_q == StRdReq) || (state_q == StRdBurst);
    assign full     = (cnt_q == CntW'(Depth));
    assign push     = wdata_valid_i && !full;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        dir_d       = dir_q;
        beat_d      = beat_q;
        tmr_d       = tmr_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        pop_n       = '0;
        cmd_ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Hold off for one cycle while done/err is being reported.
                cmd_ready_o = init_done_i && !done_q && !err_q;
                if (cmd_valid_i && cmd_ready_o) begin
                    addr_d = cmd_addr_i;
                    len_d  = cmd_len_i;
                    dir_d  = cmd_write_i;
                    beat_d = '0;
                    tmr_d  = '0;
                    if (cmd_len_i == 10'd0) begin
                        done_d = 1'b1;
                    end else if (cmd_write_i && (32'(cmd_len_i) > Depth)) begin
                        err_d = 1'b1;
                    end else if (cmd_write_i) begin
                        state_d = StWaitData;
                    end else begin
                        state_d = StRdReq;
                    end
                end
            end
            StWaitData: begin
                if (32'(cnt_q) >= 32'(len_q)) state_d = StWrReq;
            end
            StWrReq, StRdReq: begin
                // The ack-rise cycle already carries the first beat.
                if (ack) begin
                    beat_d = 10'd1;
                    if (state_q == StWrReq) pop_n = CntW'(1);
                    if (len_q == 10'd1) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = (state_q == StWrReq) ? StWrBurst : StRdBurst;
                    end
                end else if (tmr_q == TmrW'(ACK_TIMEOUT - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    if (state_q == StWrReq) pop_n = CntW'(len_q);
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StWrBurst, StRdBurst: begin
                if (ack) begin
                    beat_d = beat_q + 10'd1;
                    if (state_q == StWrBurst) pop_n = CntW'(1);
                    if (beat_d == len_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            dir_q    <= 1'b0;
            beat_q   <= '0;
            tmr_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            dir_q    <= dir_d;
            beat_q   <= beat_d;
            tmr_q    <= tmr_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rvalid_q <= rd_phase && sdram_rd_ack_i;
            if (rd_phase && sdram_rd_ack_i) rdata_q <= sdram_dout_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + FIFO_AW'(1);
            rptr_q <= rptr_q + FIFO_AW'(pop_n);
            cnt_q  <= cnt_q + CntW'(push) - pop_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wdata_i;
    end

`ifdef SDRAM_BRIDGE_STATS_EN
    logic [15:0] wr_bursts_q, rd_bursts_q;
    logic [7:0]  err_count_q;

    // dir_q still belongs to the finishing command while done_q is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_bursts_q <= '0;
            rd_bursts_q <= '0;
            err_count_q <= '0;
        end else begin
            if (done_q && dir_q) wr_bursts_q <= wr_bursts_q + 16'd1;
            if (done_q && !dir_q) rd_bursts_q <= rd_bursts_q + 16'd1;
            if (err_q && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
        end
    end

    assign wr_bursts_o = wr_bursts_q;
    assign rd_bursts_o = rd_bursts_q;
    assign err_count_o = err_count_q;
`endif

    assign wdata_ready_o    = !full;
    assign sdram_din_o      = (cnt_q == '0) ? 16'h0000 : mem_q[rptr_q];
    assign sdram_wr_req_o   = (state_q == StWrReq);
    assign sdram_rd_req_o   = (state_q == StRdReq);
    assign sdram_wr_addr_o  = addr_q;
    assign sdram_rd_addr_o  = addr_q;
    assign sdram_wr_burst_o = len_q;
    assign sdram_rd_burst_o = len_q;
    assign rdata_valid_o    = rvalid_q;
    assign rdata_o          = rdata_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_sdram_burst_bridge.sv
// Self-checking bench for sdram_burst_bridge: command table, randomized commands against a
// queue-based FIFO model, plus timeout, threshold and asynchronous-reset sequences.
module tb_sdram_burst_bridge;
    localparam int unsigned Depth = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [23:0] cmd_addr = '0;
    logic [9:0]  cmd_len = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [15:0] wdata = '0;
    logic        rdata_valid;
    logic [15:0] rdata;
    logic        done;
    logic        err;
    logic        sdram_wr_req;
    logic        sdram_wr_ack = 1'b0;
    logic [23:0] sdram_wr_addr;
    logic [9:0]  sdram_wr_burst;
    logic [15:0] sdram_din;
    logic        sdram_rd_req;
    logic        sdram_rd_ack = 1'b0;
    logic [23:0] sdram_rd_addr;
    logic [9:0]  sdram_rd_burst;
    logic [15:0] sdram_dout = '0;
`ifdef SDRAM_BRIDGE_STATS_EN
    logic [15:0] wr_bursts;
    logic [15:0] rd_bursts;
    logic [7:0]  err_count;
`endif

    sdram_burst_bridge #(
        .FIFO_AW     (4),
        .ACK_TIMEOUT (1023)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .init_done_i      (init_done),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_write_i      (cmd_write),
        .cmd_addr_i       (cmd_addr),
        .cmd_len_i        (cmd_len),
        .wdata_valid_i    (wdata_valid),
        .wdata_ready_o    (wdata_ready),
        .wdata_i          (wdata),
        .rdata_valid_o    (rdata_valid),
        .rdata_o          (rdata),
        .done_o           (done),
        .err_o            (err),
`ifdef SDRAM_BRIDGE_STATS_EN
        .wr_bursts_o      (wr_bursts),
        .rd_bursts_o      (rd_bursts),
        .err_count_o      (err_count),
`endif
        .sdram_wr_req_o   (sdram_wr_req),
        .sdram_wr_ack_i   (sdram_wr_ack),
        .sdram_wr_addr_o  (sdram_wr_addr),
        .sdram_wr_burst_o (sdram_wr_burst),
        .sdram_din_o      (sdram_din),
        .sdram_rd_req_o   (sdram_rd_req),
        .sdram_rd_ack_i   (sdram_rd_ack),
        .sdram_rd_addr_o  (sdram_rd_addr),
        .sdram_rd_burst_o (sdram_rd_burst),
        .sdram_dout_i     (sdram_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        int          len;
        int          delay;
        int          acks;
        logic [15:0] rbase;
        bit          exp_err;
        int          exp_beats;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_q[$];
    logic [15:0] next_word = 16'h1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (sdram_wr_req && sdram_rd_req) begin
                errors++;
                $display("FAIL req_exclusive: wr_req=1 rd_req=1 required not both high at %0t", $time);
            end
        end
    end

    task automatic push_word(input logic [15:0] w);
        wdata_valid = 1'b1;
        wdata       = w;
        chk("wdata_ready", wdata_ready, 1);
        tick();
        wdata_valid = 1'b0;
        model_q.push_back(w);
    endtask

    task automatic issue(input bit w, input logic [23:0] a, input int l);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = 10'(l);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called in the first cycle where req is high; cycle c of the loop carries ack when c < acks.
    task automatic ack_phase(input bit w, input int len, input int acks, input logic [15:0] rbase,
                             input int exp_beats);
        int exp_done;
        int done_at = -1;
        int ndone = 0;
        bit v;
        exp_done = (exp_beats == len) ? len : acks + 1;
        for (int c = 0; c <= exp_done + 2; c++) begin
            if (w) begin
                sdram_wr_ack = (c < acks);
            end else begin
                sdram_rd_ack = (c < acks);
                sdram_dout   = rbase + 16'(c);
            end
            chk("req_phase", w ? sdram_wr_req : sdram_rd_req, (c == 0));
            if (w && c < exp_beats) begin
                chk("wr_din", sdram_din, model_q[0]);
                void'(model_q.pop_front());
            end
            if (!w) begin
                v = (c >= 1) && (c - 1 < exp_beats);
                chk("rd_valid", rdata_valid, v);
                if (v) chk("rd_data", rdata, rbase + 16'(c - 1));
            end
            chk("err_quiet", err, 0);
            if (done) begin
                ndone++;
                done_at = c;
            end
            tick();
        end
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        chk("done_cycle", done_at, exp_done);
        chk("done_count", ndone, 1);
    endtask

    task automatic run_cmd(input vec_t t);
        if (t.wr && !t.exp_err) begin
            while (model_q.size() < t.len) begin
                push_word(next_word);
                next_word++;
            end
        end
        issue(t.wr, t.addr, t.len);
        if (t.exp_err || t.len == 0) begin
            chk("rej_err", err, t.exp_err);
            chk("rej_done", done, !t.exp_err);
            chk("rej_wr_req", sdram_wr_req, 0);
            chk("rej_rd_req", sdram_rd_req, 0);
            chk("ready_gap", cmd_ready, 0);
            tick();
            chk("ready_back", cmd_ready, 1);
            chk("rej_wr_req2", sdram_wr_req, 0);
            return;
        end
        if (t.wr) begin
            chk("wr_req_wait", sdram_wr_req, 0);
            tick();
        end
        chk("req_rise", t.wr ? sdram_wr_req : sdram_rd_req, 1);
        chk("req_addr", t.wr ? sdram_wr_addr : sdram_rd_addr, t.addr);
        chk("req_burst", t.wr ? sdram_wr_burst : sdram_rd_burst, t.len);
        for (int i = 0; i < t.delay; i++) begin
            tick();
            chk("req_hold", t.wr ? sdram_wr_req : sdram_rd_req, 1);
        end
        ack_phase(t.wr, t.len, t.acks, t.rbase, t.exp_beats);
    endtask

    // FIFO must take exactly Depth - model_q.size() more words before wdata_ready drops.
    task automatic fill_check();
        while (model_q.size() < Depth) begin
            push_word(next_word);
            next_word++;
        end
        chk("fifo_full", wdata_ready, 0);
    endtask

    task automatic timeout_run(input bit w);
        int n = 0;
        if (w) begin
            while (model_q.size() < 4) begin
                push_word(next_word);
                next_word++;
            end
        end
        issue(w, 24'h00_0ACE, 4);
        if (w) tick();
        while ((w ? sdram_wr_req : sdram_rd_req) && n < 1100) begin
            n++;
            tick();
        end
        chk("timeout_cycles", n, 1023);
        chk("timeout_err", err, 1);
        chk("timeout_done", done, 0);
        chk("timeout_ready_gap", cmd_ready, 0);
        tick();
        chk("timeout_ready_back", cmd_ready, 1);
        if (w) repeat (4) void'(model_q.pop_front());
    endtask

    initial begin
        vec_t vecs[13];
        vec_t r;
        int   l;

        vecs[0]  = '{1'b1, 24'h000100, 8, 0, 8, 16'h0000, 1'b0, 8};
        vecs[1]  = '{1'b0, 24'h000100, 8, 0, 8, 16'h1000, 1'b0, 8};
        vecs[2]  = '{1'b1, 24'h000200, 17, 0, 0, 16'h0000, 1'b1, 0};
        vecs[3]  = '{1'b0, 24'h000300, 0, 0, 0, 16'h0000, 1'b0, 0};
        vecs[4]  = '{1'b1, 24'h000400, 0, 0, 0, 16'h0000, 1'b0, 0};
        vecs[5]  = '{1'b1, 24'h0ABCDE, 5, 2, 3, 16'h0000, 1'b0, 3};
        vecs[6]  = '{1'b1, 24'h000010, 1, 0, 1, 16'h0000, 1'b0, 1};
        vecs[7]  = '{1'b1, 24'h123456, 16, 1, 16, 16'h0000, 1'b0, 16};
        vecs[8]  = '{1'b0, 24'hFFFFF0, 12, 3, 12, 16'hBEEF, 1'b0, 12};
        vecs[9]  = '{1'b0, 24'h000020, 4, 0, 2, 16'h5555, 1'b0, 2};
        vecs[10] = '{1'b1, 24'h000030, 1023, 0, 0, 16'h0000, 1'b1, 0};
        vecs[11] = '{1'b1, 24'h000040, 16, 0, 20, 16'h0000, 1'b0, 16};
        vecs[12] = '{1'b0, 24'h000050, 1, 1, 3, 16'h0A0A, 1'b0, 1};

        // Reset values and init gating.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wdata_ready", wdata_ready, 1);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_req", sdram_wr_req, 0);
        chk("rst_rd_req", sdram_rd_req, 0);
        chk("rst_wr_addr", sdram_wr_addr, 0);
        chk("rst_wr_burst", sdram_wr_burst, 0);
        chk("rst_rd_addr", sdram_rd_addr, 0);
        chk("rst_rd_burst", sdram_rd_burst, 0);
        chk("rst_din", sdram_din, 0);
        rst = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_len   = 10'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("noinit_ready", cmd_ready, 0);
            chk("noinit_rd_req", sdram_rd_req, 0);
        end
        cmd_valid = 1'b0;
        init_done = 1'b1;
        #1;
        chk("init_ready", cmd_ready, 1);

        for (int i = 0; i < 13; i++) run_cmd(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            l           = $urandom_range(0, 20);
            r.wr        = $urandom_range(0, 1);
            r.addr      = 24'($urandom);
            r.len       = l;
            r.delay     = $urandom_range(0, 3);
            r.acks      = $urandom_range(1, l + 2);
            r.rbase     = 16'($urandom);
            r.exp_err   = r.wr && (l > Depth);
            r.exp_beats = (l < r.acks) ? l : r.acks;
            run_cmd(r);
        end

        timeout_run(1'b0);
        timeout_run(1'b1);
        fill_check();
        run_cmd('{1'b1, 24'h0000AA, 16, 0, 16, 16'h0000, 1'b0, 16});

        // Threshold wait: three words resident, request must wait for the fourth.
        for (int i = 0; i < 3; i++) begin
            push_word(next_word);
            next_word++;
        end
        issue(1'b1, 24'h000600, 4);
        for (int i = 0; i < 5; i++) begin
            chk("thr_wait", sdram_wr_req, 0);
            tick();
        end
        wdata_valid = 1'b1;
        wdata       = next_word;
        chk("thr_before_push", sdram_wr_req, 0);
        tick();
        wdata_valid = 1'b0;
        model_q.push_back(next_word);
        next_word++;
        chk("thr_met_cycle", sdram_wr_req, 0);
        tick();
        chk("thr_req_rise", sdram_wr_req, 1);
        ack_phase(1'b1, 4, 4, 16'h0000, 4);

        // Asynchronous reset during beat 3 of a 16-word write.
        fill_check();
        issue(1'b1, 24'h000777, 16);
        tick();
        chk("ar_req", sdram_wr_req, 1);
        for (int c = 0; c < 3; c++) begin
            sdram_wr_ack = 1'b1;
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("ar_wr_req", sdram_wr_req, 0);
        chk("ar_wdata_ready", wdata_ready, 1);
        chk("ar_done", done, 0);
        chk("ar_err", err, 0);
        sdram_wr_ack = 1'b0;
        model_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_done = 1'b0;
        #1;
        chk("ar_ready_noinit", cmd_ready, 0);
        init_done = 1'b1;
        #1;
        chk("ar_ready_init", cmd_ready, 1);
        tick();
        chk("ar_no_done", done, 0);
        chk("ar_no_err", err, 0);
        fill_check();
        run_cmd('{1'b1, 24'h0000BB, 16, 0, 16, 16'h0000, 1'b0, 16});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the end, required completion");
        $fatal(1);
    end

endmodule
